rf_wb_arbiter: RTL

- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters.
  - Requester A is the ALU writeback.
  - Requester B is the load/memory writeback.
- Fixed priority to A, with an anti-starvation counter that forces one grant to B after B has waited STARVE_LIMIT cycles.
- Outputs are registered and drive the register file write port directly; the register file ignores address 0 on its own.

---
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester writeback arbiter for the register file write port
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [4:0]    a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we3,
  output logic [4:0]    wa3,
  output logic [DW-1:0] wd3,
  output logic          b_forced
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;
  logic       gnt_a;
  logic       gnt_b;
  logic       b_blocked;

  // State register; b_forced is a direct decode of the registered state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PRI_A;
    end else begin
      state <= state_next;
    end
  end

  assign b_forced = (state == PRI_B);

  // Readies never look at their own valid, so a requester can rely on them combinationally
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!hold) begin
      a_ready = (state == PRI_A) || !b_valid;
      b_ready = (state == PRI_B) || !a_valid;
    end
  end

  assign gnt_a     = a_valid && a_ready;
  assign gnt_b     = b_valid && b_ready;
  assign b_blocked = b_valid && !b_ready && !hold;

  // Next state: escalate to B after it has been blocked long enough; one grant (or withdrawal) drops back
  always_comb begin
    state_next = state;
    if (!hold) begin
      case (state)
        PRI_A: if (b_blocked && (wait_cnt == LIMIT_M1)) state_next = PRI_B;
        PRI_B: if (gnt_b || !b_valid) state_next = PRI_A;
        default: state_next = PRI_A;
      endcase
    end
  end

  // Starvation counter: counts blocked cycles of B, saturates, frozen under hold
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!hold) begin
      if (gnt_b || !b_valid) begin
        wait_cnt_next = 4'd0;
      end else if (b_blocked && (wait_cnt < LIMIT)) begin
        wait_cnt_next = wait_cnt + 4'd1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Registered write port; r0 grants are consumed but never enable the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= 5'd0;
      wd3 <= '0;
    end else if (gnt_a) begin
      we3 <= (a_addr != 5'd0);
      wa3 <= a_addr;
      wd3 <= a_data;
    end else if (gnt_b) begin
      we3 <= (b_addr != 5'd0);
      wa3 <= b_addr;
      wd3 <= b_data;
    end else begin
      we3 <= 1'b0;
    end
  end

endmodule
